// File: rtl/demux_32_bit_4sel_stream.sv
// 1-to-4 registered stream demultiplexer with a one-entry buffer per channel
// and per-channel delivered-word counters.
module demux_32_bit_4sel_stream #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_select,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data_0,
    output logic [WIDTH-1:0]   out_data_1,
    output logic [WIDTH-1:0]   out_data_2,
    output logic [WIDTH-1:0]   out_data_3,
    output logic               out_valid_0,
    output logic               out_valid_1,
    output logic               out_valid_2,
    output logic               out_valid_3,
    input  logic               out_ready_0,
    input  logic               out_ready_1,
    input  logic               out_ready_2,
    input  logic               out_ready_3,
    output logic [COUNT_W-1:0] count_0,
    output logic [COUNT_W-1:0] count_1,
    output logic [COUNT_W-1:0] count_2,
    output logic [COUNT_W-1:0] count_3
);

    logic [3:0]         out_ready_v;
    logic [3:0]         deliver;
    logic               accept;
    logic [3:0]         full_q, full_d;
    logic [WIDTH-1:0]   data_q [4];
    logic [WIDTH-1:0]   data_d [4];
    logic [COUNT_W-1:0] cnt_q  [4];
    logic [COUNT_W-1:0] cnt_d  [4];

    assign out_ready_v = {out_ready_3, out_ready_2, out_ready_1, out_ready_0};

    // Only the selected channel can block input; a draining buffer accepts.
    assign in_ready = ~full_q[in_select] | out_ready_v[in_select];
    assign accept   = in_valid & in_ready;
    assign deliver  = full_q & out_ready_v;

    always_comb begin
        full_d = full_q;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = data_q[k];
            cnt_d[k]  = cnt_q[k] + COUNT_W'(deliver[k]);
            if (deliver[k]) begin
                full_d[k] = 1'b0;
            end
            if (accept && (in_select == 2'(k))) begin
                full_d[k] = 1'b1;
                data_d[k] = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign out_valid_0 = full_q[0];
    assign out_valid_1 = full_q[1];
    assign out_valid_2 = full_q[2];
    assign out_valid_3 = full_q[3];
    assign out_data_0  = data_q[0];
    assign out_data_1  = data_q[1];
    assign out_data_2  = data_q[2];
    assign out_data_3  = data_q[3];
    assign count_0     = cnt_q[0];
    assign count_1     = cnt_q[1];
    assign count_2     = cnt_q[2];
    assign count_3     = cnt_q[3];

endmodule

// File: tb/tb_demux_32_bit_4sel_stream.sv
// Randomized and directed bench for demux_32_bit_4sel_stream against a
// queue-based per-channel model.
module tb_demux_32_bit_4sel_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data = '0;
    logic [1:0]  in_select = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ready_v = '0;
    logic [31:0] od0, od1, od2, od3;
    logic        ov0, ov1, ov2, ov3;
    logic [7:0]  c0, c1, c2, c3;

    logic [31:0] obs_data [4];
    logic        obs_valid [4];
    logic [7:0]  obs_cnt [4];

    logic [31:0] mq [4][$];
    int          mcnt [4];
    logic        rdy_obs, rdy_exp;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    demux_32_bit_4sel_stream dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_select(in_select),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data_0(od0), .out_data_1(od1),
        .out_data_2(od2), .out_data_3(od3),
        .out_valid_0(ov0), .out_valid_1(ov1),
        .out_valid_2(ov2), .out_valid_3(ov3),
        .out_ready_0(ready_v[0]), .out_ready_1(ready_v[1]),
        .out_ready_2(ready_v[2]), .out_ready_3(ready_v[3]),
        .count_0(c0), .count_1(c1), .count_2(c2), .count_3(c3)
    );

    always_comb begin
        obs_data[0] = od0; obs_data[1] = od1;
        obs_data[2] = od2; obs_data[3] = od3;
        obs_valid[0] = ov0; obs_valid[1] = ov1;
        obs_valid[2] = ov2; obs_valid[3] = ov3;
        obs_cnt[0] = c0; obs_cnt[1] = c1;
        obs_cnt[2] = c2; obs_cnt[3] = c3;
    end

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            mcnt[k] = 0;
        end
    endtask

    // Drive one cycle of stimulus and advance the model across the edge.
    task automatic step(input logic [31:0] d, input logic [1:0] s,
                        input logic v, input logic [3:0] r);
        @(negedge clk);
        in_data = d; in_select = s; in_valid = v; ready_v = r;
        #1;
        rdy_obs = in_ready;
        rdy_exp = (mq[s].size() == 0) || r[s];
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (mq[k].size() != 0 && r[k]) begin
                void'(mq[k].pop_front());
                mcnt[k] = (mcnt[k] + 1) % 256;
            end
        end
        if (v && rdy_exp) mq[s].push_back(d);
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_chk += 3;
            if (obs_valid[k] !== 1'b0) $display("FAIL reset_valid%0d got %b want 0", k, obs_valid[k]);
            else n_pass++;
            if (obs_data[k] !== 32'h0) $display("FAIL reset_data%0d got %h want 0", k, obs_data[k]);
            else n_pass++;
            if (obs_cnt[k] !== 8'h0) $display("FAIL reset_cnt%0d got %h want 0", k, obs_cnt[k]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] w [4];
        w[0] = 32'hAAAA0000; w[1] = 32'hBBBB0001;
        w[2] = 32'hCCCC0002; w[3] = 32'hDDDD0003;
        for (int i = 0; i < 4; i++) begin
            step(w[i], 2'(i), 1'b1, 4'hF);
            n_chk += 3;
            if (rdy_obs !== 1'b1) $display("FAIL basic_rdy%0d got %b want 1", i, rdy_obs);
            else n_pass++;
            if (obs_valid[i] !== 1'b1) $display("FAIL basic_valid%0d got %b want 1", i, obs_valid[i]);
            else n_pass++;
            if (obs_data[i] !== w[i]) $display("FAIL basic_data%0d got %h want %h", i, obs_data[i], w[i]);
            else n_pass++;
        end
        step('0, 2'd0, 1'b0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            n_chk += 2;
            if (obs_cnt[k] !== 8'd1) $display("FAIL basic_cnt%0d got %0d want 1", k, obs_cnt[k]);
            else n_pass++;
            if (obs_valid[k] !== 1'b0) $display("FAIL basic_drain%0d got %b want 0", k, obs_valid[k]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        step(32'h12345678, 2'd2, 1'b1, 4'b1011);
        step(32'h9ABCDEF0, 2'd2, 1'b1, 4'b1011);
        n_chk += 3;
        if (rdy_obs !== 1'b0) $display("FAIL bp_refuse got %b want 0", rdy_obs);
        else n_pass++;
        if (od2 !== 32'h12345678) $display("FAIL bp_hold got %h want 12345678", od2);
        else n_pass++;
        if (c2 !== 8'd1) $display("FAIL bp_cnt0 got %0d want 1", c2);
        else n_pass++;
        step(32'h9ABCDEF0, 2'd2, 1'b1, 4'b1111);
        n_chk += 4;
        if (rdy_obs !== 1'b1) $display("FAIL bp_accept got %b want 1", rdy_obs);
        else n_pass++;
        if (ov2 !== 1'b1) $display("FAIL bp_valid got %b want 1", ov2);
        else n_pass++;
        if (od2 !== 32'h9ABCDEF0) $display("FAIL bp_data2 got %h want 9abcdef0", od2);
        else n_pass++;
        if (c2 !== 8'd2) $display("FAIL bp_cnt1 got %0d want 2", c2);
        else n_pass++;
        step('0, 2'd0, 1'b0, 4'hF);
        n_chk += 2;
        if (c2 !== 8'd3) $display("FAIL bp_cnt2 got %0d want 3", c2);
        else n_pass++;
        if (ov2 !== 1'b0) $display("FAIL bp_drain got %b want 0", ov2);
        else n_pass++;
    endtask

    task automatic test_independence();
        step(32'h11111111, 2'd1, 1'b1, 4'b1101);
        step(32'h00000055, 2'd3, 1'b1, 4'b0101);
        n_chk += 5;
        if (rdy_obs !== 1'b1) $display("FAIL ind_rdy got %b want 1", rdy_obs);
        else n_pass++;
        if (ov3 !== 1'b1 || od3 !== 32'h55) $display("FAIL ind_ch3 got %b/%h want 1/00000055", ov3, od3);
        else n_pass++;
        if (ov1 !== 1'b1 || od1 !== 32'h11111111) $display("FAIL ind_ch1 got %b/%h want 1/11111111", ov1, od1);
        else n_pass++;
        step('0, 2'd0, 1'b0, 4'b1101);
        if (c3 !== 8'd2) $display("FAIL ind_cnt3 got %0d want 2", c3);
        else n_pass++;
        if (od1 !== 32'h11111111) $display("FAIL ind_hold1 got %h want 11111111", od1);
        else n_pass++;
        step('0, 2'd0, 1'b0, 4'hF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 4'($urandom));
            n_chk++;
            if (rdy_obs !== rdy_exp) $display("FAIL rnd_rdy cyc%0d got %b want %b", i, rdy_obs, rdy_exp);
            else n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_chk += 2;
                if (obs_valid[k] !== (mq[k].size() != 0))
                    $display("FAIL rnd_valid%0d cyc%0d got %b want %b", k, i, obs_valid[k], mq[k].size() != 0);
                else n_pass++;
                if (obs_cnt[k] !== 8'(mcnt[k]))
                    $display("FAIL rnd_cnt%0d cyc%0d got %0d want %0d", k, i, obs_cnt[k], mcnt[k]);
                else n_pass++;
                if (mq[k].size() != 0) begin
                    n_chk++;
                    if (obs_data[k] !== mq[k][0])
                        $display("FAIL rnd_data%0d cyc%0d got %h want %h", k, i, obs_data[k], mq[k][0]);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        step(32'hCAFE0000, 2'd0, 1'b1, 4'h0);
        step(32'hCAFE0002, 2'd2, 1'b1, 4'h0);
        @(negedge clk);
        ready_v = 4'h0; in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            n_chk += 3;
            if (obs_valid[k] !== 1'b0) $display("FAIL midrst_valid%0d got %b want 0", k, obs_valid[k]);
            else n_pass++;
            if (obs_data[k] !== 32'h0) $display("FAIL midrst_data%0d got %h want 0", k, obs_data[k]);
            else n_pass++;
            if (obs_cnt[k] !== 8'h0) $display("FAIL midrst_cnt%0d got %h want 0", k, obs_cnt[k]);
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        step('0, 2'd0, 1'b0, 4'hF);
        step('0, 2'd0, 1'b0, 4'hF);
        for (int k = 0; k < 4; k++) begin
            n_chk += 2;
            if (obs_valid[k] !== 1'b0) $display("FAIL midrst_post_valid%0d got %b want 0", k, obs_valid[k]);
            else n_pass++;
            if (obs_cnt[k] !== 8'h0) $display("FAIL midrst_post_cnt%0d got %0d want 0", k, obs_cnt[k]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            step(w, 2'd0, 1'b1, 4'hF);
            n_chk += 3;
            if (rdy_obs !== 1'b1) $display("FAIL b2b_rdy%0d got %b want 1", i, rdy_obs);
            else n_pass++;
            if (ov0 !== 1'b1 || od0 !== w) $display("FAIL b2b_data%0d got %b/%h want 1/%h", i, ov0, od0, w);
            else n_pass++;
            if (c0 !== 8'(i)) $display("FAIL b2b_cnt%0d got %0d want %0d", i, c0, i);
            else n_pass++;
        end
        step('0, 2'd0, 1'b0, 4'hF);
        n_chk += 3;
        if (c0 !== 8'h00) $display("FAIL b2b_wrap got %h want 00", c0);
        else n_pass++;
        if (ov0 !== 1'b0) $display("FAIL b2b_drain got %b want 0", ov0);
        else n_pass++;
        if ({c1, c2, c3} !== 24'h0) $display("FAIL b2b_others got %h want 0", {c1, c2, c3});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_independence();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
